// File: rtl/slow_window_if.sv
// Bus-side view of the slow-window tracker: access strobe, device selects,
// settings-register enables in; clock-select/clock-gate decisions out.
interface slow_window_if;
    logic       BACT;
    logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       Slow, SlowGate, SlowBusy;

    modport master (
        output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR,
        output SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
        output SlowClockGate, SlowTimeout,
        input  Slow, SlowGate, SlowBusy
    );

    modport slave (
        input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR,
        input  SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd,
        input  SlowClockGate, SlowTimeout,
        output Slow, SlowGate, SlowBusy
    );
endinterface

// File: rtl/slow_window.sv
// Holds the CPU at stock speed while an enabled slow peripheral is accessed,
// plus SlowTimeout prescaled ticks after the access ends.
module slow_window #(
    parameter int PRESCALE = 256
) (
    input  logic         CLK,
    input  logic         POR,
    slow_window_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          bact_q;
    logic          slow_q, gate_q, busy_q;
    logic          slow_hit, end_acc, slow_d;

    assign slow_hit = bus.BACT & |{bus.IACKCS  & bus.SlowIACK,
                                   bus.VIACS   & bus.SlowVIA,
                                   bus.IWMCS   & bus.SlowIWM,
                                   bus.SCCCS   & bus.SlowSCC,
                                   bus.SCSICS  & bus.SlowSCSI,
                                   bus.SndCSWR & bus.SlowSnd};
    assign end_acc  = bact_q & ~bus.BACT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        case (state_q)
            IDLE: begin
                if (slow_hit) state_d = ACCESS;
            end
            ACCESS: begin
                if (end_acc) begin
                    state_d = (bus.SlowTimeout == 4'd0) ? IDLE : HOLD;
                    cnt_d   = bus.SlowTimeout;
                    pre_d   = '0;
                end
            end
            HOLD: begin
                // A new slow access beats expiry; the count is reloaded when it ends.
                if (slow_hit) begin
                    state_d = ACCESS;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = IDLE;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign slow_d = (state_d != IDLE);

    always_ff @(posedge CLK) begin
        if (POR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            bact_q  <= 1'b0;
            slow_q  <= 1'b0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            bact_q  <= bus.BACT;
            slow_q  <= slow_d;
            gate_q  <= slow_d & bus.SlowClockGate;
            busy_q  <= (state_d == HOLD);
        end
    end

    assign bus.Slow     = slow_q;
    assign bus.SlowGate = gate_q;
    assign bus.SlowBusy = busy_q;
endmodule

// File: tb/tb_slow_window.sv
// Directed scoreboard bench for slow_window (PRESCALE=4): each stimulus cycle
// queues its expected {Slow,SlowGate,SlowBusy}; a monitor pops after every edge.
module tb_slow_window;
    logic CLK = 1'b0;
    logic POR;
    always #5 CLK = ~CLK;

    slow_window_if bus ();

    slow_window #(.PRESCALE(4)) dut (
        .CLK (CLK),
        .POR (POR),
        .bus (bus)
    );

    typedef struct {
        logic [2:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Selects/enables ordering: {Snd, SCSI, SCC, IWM, VIA, IACK}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] IACK = 6'b000001;
    localparam logic [5:0] VIA  = 6'b000010;
    localparam logic [5:0] IWM  = 6'b000100;
    localparam logic [5:0] SCC  = 6'b001000;
    localparam logic [5:0] SND  = 6'b100000;

    logic       por_v = 1'b1;
    logic       cg_v  = 1'b0;
    logic [3:0] to_v  = 4'd0;

    task automatic run(input int n, input logic b, input logic [5:0] cs,
                       input logic [2:0] e, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            POR               = por_v;
            bus.SlowClockGate = cg_v;
            bus.SlowTimeout   = to_v;
            bus.BACT          = b;
            {bus.SndCSWR, bus.SCSICS, bus.SCCCS, bus.IWMCS, bus.VIACS, bus.IACKCS} = b ? cs : NONE;
            sb.push_back('{e, tag});
        end
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.Slow, bus.SlowGate, bus.SlowBusy} !== e.v) begin
                errors++;
                $display("FAIL %s: got {Slow,Gate,Busy}=%b expected %b at %0t",
                         e.tag, {bus.Slow, bus.SlowGate, bus.SlowBusy}, e.v, $time);
            end
        end
    end

    initial begin
        POR  = 1'b1;
        bus.BACT = 1'b0;
        {bus.SndCSWR, bus.SCSICS, bus.SCCCS, bus.IWMCS, bus.VIACS, bus.IACKCS} = NONE;
        {bus.SlowSnd, bus.SlowSCSI, bus.SlowSCC, bus.SlowIWM, bus.SlowVIA, bus.SlowIACK} = 6'b111011;
        bus.SlowClockGate = 1'b0;
        bus.SlowTimeout   = 4'd0;

        // Reset beats a simultaneous slow hit; window opens one edge after release
        por_v = 1'b1; cg_v = 1'b1; to_v = 4'd3;
        run(2,  1'b1, VIA,  3'b000, "reset");
        por_v = 1'b0;
        run(5,  1'b1, VIA,  3'b110, "post_reset_access");
        run(12, 1'b0, NONE, 3'b111, "post_reset_hold");
        run(2,  1'b0, NONE, 3'b000, "post_reset_idle");

        // Basic window with gating disabled: 3 ticks * 4 = 12 HOLD cycles
        cg_v = 1'b0;
        run(1,  1'b0, NONE, 3'b000, "basic_pre");
        run(5,  1'b1, VIA,  3'b100, "basic_access");
        run(12, 1'b0, NONE, 3'b101, "basic_hold");
        run(2,  1'b0, NONE, 3'b000, "basic_expire");

        // Zero timeout: Slow mirrors BACT delayed by one cycle
        to_v = 4'd0;
        run(3,  1'b1, SCC,  3'b100, "zero_to_access");
        run(2,  1'b0, NONE, 3'b000, "zero_to_end");
        run(1,  1'b1, IACK, 3'b100, "iack_access");
        run(1,  1'b0, NONE, 3'b000, "iack_end");
        run(2,  1'b1, SND,  3'b100, "snd_access");
        run(1,  1'b0, NONE, 3'b000, "snd_end");

        // Disabled device never opens a window
        to_v = 4'd3;
        run(4,  1'b1, IWM,  3'b000, "iwm_disabled");
        run(2,  1'b0, NONE, 3'b000, "iwm_idle");

        // Fast RAM access in HOLD leaves the 4-cycle countdown intact
        to_v = 4'd1;
        run(2,  1'b1, VIA,  3'b100, "fast_access");
        run(1,  1'b0, NONE, 3'b101, "fast_hold_a");
        run(2,  1'b1, NONE, 3'b101, "fast_hold_ram");
        run(1,  1'b0, NONE, 3'b101, "fast_hold_b");
        run(2,  1'b0, NONE, 3'b000, "fast_expire");

        // Retrigger 3 cycles into HOLD; timeout change mid-HOLD is ignored
        to_v = 4'd2;
        run(2,  1'b1, VIA,  3'b100, "retrig_first");
        run(3,  1'b0, NONE, 3'b101, "retrig_hold1");
        run(2,  1'b1, VIA,  3'b100, "retrig_second");
        run(1,  1'b0, NONE, 3'b101, "retrig_hold2a");
        to_v = 4'd15;
        run(7,  1'b0, NONE, 3'b101, "retrig_hold2b");
        run(2,  1'b0, NONE, 3'b000, "retrig_expire");

        // Slow hit on the exact expiry edge keeps Slow asserted
        to_v = 4'd1;
        run(2,  1'b1, VIA,  3'b100, "edge_access");
        run(4,  1'b0, NONE, 3'b101, "edge_hold1");
        run(1,  1'b1, VIA,  3'b100, "edge_retrig");
        run(4,  1'b0, NONE, 3'b101, "edge_hold2");
        run(1,  1'b0, NONE, 3'b000, "edge_expire");

        // Gate enabled mid-HOLD, then reset mid-HOLD
        to_v = 4'd3; cg_v = 1'b0;
        run(2,  1'b1, VIA,  3'b100, "gate_access");
        run(3,  1'b0, NONE, 3'b101, "gate_off_hold");
        cg_v = 1'b1;
        run(2,  1'b0, NONE, 3'b111, "gate_on_hold");
        por_v = 1'b1;
        run(1,  1'b0, NONE, 3'b000, "por_mid_hold");
        por_v = 1'b0;
        run(2,  1'b0, NONE, 3'b000, "por_after");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
